// File: rtl/sprite_pkg.sv
// rtl/sprite_pkg.sv - shared types and constants for the sprite compositor
package sprite_pkg;

    typedef logic [23:0] rgb_t;
    typedef logic [9:0]  coord_t;

    localparam rgb_t BG_DEFAULT  = 24'hffffff;
    localparam rgb_t KEY_DEFAULT = 24'hff00ff;

    localparam int BTN_UP    = 3;
    localparam int BTN_DOWN  = 4;
    localparam int BTN_LEFT  = 5;
    localparam int BTN_RIGHT = 6;

endpackage

// File: rtl/sprite_channel.sv
// rtl/sprite_channel.sv - one sprite: motion, hit test, ROM lookup, delayed in-box flag
module sprite_channel import sprite_pkg::*; #(
    parameter int IDX         = 0,
    parameter int SPRITE_LOG2 = 6,
    parameter int H_RES       = 640,
    parameter int V_RES       = 480
) (
    input  logic       clk_25mhz,
    input  logic       resetn,
    input  logic       update,
    input  logic [6:0] btn,
    input  logic [9:0] x,
    input  logic [9:0] y,
    output rgb_t       data,
    output logic       inbox
);

    localparam int     L     = SPRITE_LOG2;
    localparam int     SIZE  = 1 << L;
    localparam coord_t X_MAX = coord_t'(H_RES - SIZE);
    localparam coord_t Y_MAX = coord_t'(V_RES - SIZE);
    localparam coord_t X0    = coord_t'((IDX * 2 * SIZE) % (H_RES - SIZE));
    localparam coord_t Y0    = coord_t'((IDX * SIZE) % (V_RES - SIZE));
    localparam logic   NEG_X0 = (IDX % 2 == 0);

    coord_t pos_x_q, pos_x_d, pos_y_q, pos_y_d;
    logic   neg_x_q, neg_x_d, neg_y_q, neg_y_d;
    logic   inbox_q, inbox_d;
    logic [L-1:0]   dx, dy;
    logic [2*L-1:0] addr;

    // once-per-update motion: sprite 0 steered by buttons, others bounce off the edges
    always_comb begin
        pos_x_d = pos_x_q;
        pos_y_d = pos_y_q;
        neg_x_d = neg_x_q;
        neg_y_d = neg_y_q;
        if (update) begin
            if (IDX == 0) begin
                if (btn[BTN_RIGHT] && !btn[BTN_LEFT] && pos_x_q < X_MAX) pos_x_d = pos_x_q + 1'b1;
                if (btn[BTN_LEFT] && !btn[BTN_RIGHT] && pos_x_q != '0)  pos_x_d = pos_x_q - 1'b1;
                if (btn[BTN_DOWN] && !btn[BTN_UP] && pos_y_q < Y_MAX)    pos_y_d = pos_y_q + 1'b1;
                if (btn[BTN_UP] && !btn[BTN_DOWN] && pos_y_q != '0)      pos_y_d = pos_y_q - 1'b1;
            end else begin
                if (neg_x_q ? (pos_x_q == '0) : (pos_x_q == X_MAX)) neg_x_d = !neg_x_q;
                else pos_x_d = neg_x_q ? pos_x_q - 1'b1 : pos_x_q + 1'b1;
                if (neg_y_q ? (pos_y_q == '0) : (pos_y_q == Y_MAX)) neg_y_d = !neg_y_q;
                else pos_y_d = neg_y_q ? pos_y_q - 1'b1 : pos_y_q + 1'b1;
            end
        end
    end

    // stage 0 hit test in 11 bits so the box never wraps; texel address from the low offset bits
    always_comb begin
        inbox_d = ({1'b0, x} >= {1'b0, pos_x_q}) && ({1'b0, x} < {1'b0, pos_x_q} + 11'(SIZE)) &&
                  ({1'b0, y} >= {1'b0, pos_y_q}) && ({1'b0, y} < {1'b0, pos_y_q} + 11'(SIZE));
        dx      = x[L-1:0] - pos_x_q[L-1:0];
        dy      = y[L-1:0] - pos_y_q[L-1:0];
        addr    = {dy, dx};
    end

    // position, direction and in-box delay registers
    always_ff @(posedge clk_25mhz or negedge resetn) begin
        if (!resetn) begin
            pos_x_q <= X0;
            pos_y_q <= Y0;
            neg_x_q <= NEG_X0;
            neg_y_q <= 1'b0;
            inbox_q <= 1'b0;
        end else begin
            pos_x_q <= pos_x_d;
            pos_y_q <= pos_y_d;
            neg_x_q <= neg_x_d;
            neg_y_q <= neg_y_d;
            inbox_q <= inbox_d;
        end
    end

    sprite_rom #(.ID(IDX), .ADDR_W(2 * L)) u_rom (
        .clk_25mhz (clk_25mhz),
        .resetn    (resetn),
        .addr      (addr),
        .data      (data)
    );

    assign inbox = inbox_q;

endmodule

// File: rtl/sprite_rom.sv
// rtl/sprite_rom.sv - sprite texture ROM with one-cycle synchronous read
module sprite_rom import sprite_pkg::*; #(
    parameter int ID     = 0,
    parameter int ADDR_W = 12
) (
    input  logic              clk_25mhz,
    input  logic              resetn,
    input  logic [ADDR_W-1:0] addr,
    output rgb_t              data
);

    localparam int L = ADDR_W / 2;

    logic [L-1:0] row;
    logic [L-1:0] col;
    rgb_t         data_d;
    rgb_t         data_q;

    // texture: sprite id tag, row, column; key colour punches a grid of holes at (5,5) mod 8
    always_comb begin
        row = addr[ADDR_W-1:L];
        col = addr[L-1:0];
        if (row[2:0] == 3'd5 && col[2:0] == 3'd5) begin
            data_d = KEY_DEFAULT;
        end else begin
            data_d = {8'(ID + 64), 8'(row), 8'(col)};
        end
    end

    // registered read port
    always_ff @(posedge clk_25mhz or negedge resetn) begin
        if (!resetn) data_q <= '0;
        else         data_q <= data_d;
    end

    assign data = data_q;

endmodule

// File: rtl/sprite_compositor.sv
// rtl/sprite_compositor.sv - sprite overlay top; define SPRITE_COLLISION_EN for the overlap flag
module sprite_compositor import sprite_pkg::*; #(
    parameter int   NUM_SPRITES = 4,
    parameter int   SPRITE_LOG2 = 6,
    parameter int   H_RES       = 640,
    parameter int   V_RES       = 480,
    parameter rgb_t BG_COLOR    = BG_DEFAULT,
    parameter rgb_t KEY_COLOR   = KEY_DEFAULT,
    parameter int   MOVE_DIV    = 1
) (
    input  logic                   clk_25mhz,
    input  logic                   resetn,
    input  logic [9:0]             x,
    input  logic [9:0]             y,
    input  logic                   frame_tick,
    input  logic [6:0]             btn,
    output logic [23:0]            color,
    output logic [NUM_SPRITES-1:0] hit_mask,
    output logic                   collision
);

    logic [6:0] btn_meta_q, btn_meta_d, btn_sync_q, btn_sync_d;
    logic [7:0] div_q, div_d;
    logic       update;
    rgb_t       spr_data [NUM_SPRITES];
    logic [NUM_SPRITES-1:0] inbox, opaque;
    rgb_t       color_q, color_d;
    logic [NUM_SPRITES-1:0] hit_q, hit_d;

    // button synchronizer and frame divider producing the motion update pulse
    always_comb begin
        btn_meta_d = btn;
        btn_sync_d = btn_meta_q;
        div_d      = div_q;
        update     = 1'b0;
        if (frame_tick) begin
            if (div_q == 8'(MOVE_DIV - 1)) begin
                update = 1'b1;
                div_d  = '0;
            end else begin
                div_d  = div_q + 1'b1;
            end
        end
    end

    for (genvar i = 0; i < NUM_SPRITES; i++) begin : g_spr
        sprite_channel #(
            .IDX         (i),
            .SPRITE_LOG2 (SPRITE_LOG2),
            .H_RES       (H_RES),
            .V_RES       (V_RES)
        ) u_ch (
            .clk_25mhz (clk_25mhz),
            .resetn    (resetn),
            .update    (update),
            .btn       (btn_sync_q),
            .x         (x),
            .y         (y),
            .data      (spr_data[i]),
            .inbox     (inbox[i])
        );
    end

    // priority mux: scan high index to low so the lowest opaque index wins
    always_comb begin
        color_d = BG_COLOR;
        opaque  = '0;
        for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
            opaque[i] = inbox[i] && (spr_data[i] != KEY_COLOR);
            if (opaque[i]) color_d = spr_data[i];
        end
        hit_d = opaque;
    end

    // synchronizer, divider and output registers
    always_ff @(posedge clk_25mhz or negedge resetn) begin
        if (!resetn) begin
            btn_meta_q <= '0;
            btn_sync_q <= '0;
            div_q      <= '0;
            color_q    <= BG_COLOR;
            hit_q      <= '0;
        end else begin
            btn_meta_q <= btn_meta_d;
            btn_sync_q <= btn_sync_d;
            div_q      <= div_d;
            color_q    <= color_d;
            hit_q      <= hit_d;
        end
    end

    assign color    = color_q;
    assign hit_mask = hit_q;

`ifdef SPRITE_COLLISION_EN
    logic       collision_q, collision_d;
    logic [3:0] hits;

    // sticky overlap flag; frame_tick clears it and wins over a same-cycle set
    always_comb begin
        hits = '0;
        for (int i = 0; i < NUM_SPRITES; i++) hits = hits + 4'(hit_q[i]);
        collision_d = collision_q;
        if (frame_tick)          collision_d = 1'b0;
        else if (hits >= 4'd2)   collision_d = 1'b1;
    end

    // collision flag register
    always_ff @(posedge clk_25mhz or negedge resetn) begin
        if (!resetn) collision_q <= 1'b0;
        else         collision_q <= collision_d;
    end

    assign collision = collision_q;
`else
    assign collision = 1'b0;
`endif

endmodule

// File: tb/tb_sprite_compositor.sv
// tb/tb_sprite_compositor.sv - scoreboard bench for sprite_compositor
module tb_sprite_compositor;

    localparam int N    = 4;
    localparam int SIZE = 64;
    localparam int XM   = 640 - SIZE;
    localparam int YM   = 480 - SIZE;
    localparam logic [23:0] BG  = 24'hffffff;
    localparam logic [23:0] KEY = 24'hff00ff;

    logic           clk_25mhz = 1'b0;
    logic           resetn    = 1'b0;
    logic           frame_tick = 1'b0;
    logic [9:0]     x = '0;
    logic [9:0]     y = '0;
    logic [6:0]     btn = '0;
    logic [23:0]    color;
    logic [N-1:0]   hit_mask;
    logic           collision;

    sprite_compositor dut (
        .clk_25mhz  (clk_25mhz),
        .resetn     (resetn),
        .x          (x),
        .y          (y),
        .frame_tick (frame_tick),
        .btn        (btn),
        .color      (color),
        .hit_mask   (hit_mask),
        .collision  (collision)
    );

    always #20 clk_25mhz = ~clk_25mhz;

    typedef struct {
        int           stamp;
        int           px;
        int           py;
        logic [23:0]  color;
        logic [N-1:0] mask;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   px[N], py[N], vx[N], vy[N];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [23:0] texel(input int id, input int row, input int col);
        if (row % 8 == 5 && col % 8 == 5) return KEY;
        return {8'(64 + id), 8'(row), 8'(col)};
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < N; i++) begin
            px[i] = (i * 2 * SIZE) % XM;
            py[i] = (i * SIZE) % YM;
            vx[i] = (i % 2 == 1) ? 1 : -1;
            vy[i] = 1;
        end
    endfunction

    function automatic void model_update(input logic [6:0] b);
        if (b[6] && !b[5] && px[0] < XM) px[0]++;
        if (b[5] && !b[6] && px[0] > 0)  px[0]--;
        if (b[4] && !b[3] && py[0] < YM) py[0]++;
        if (b[3] && !b[4] && py[0] > 0)  py[0]--;
        for (int i = 1; i < N; i++) begin
            if (px[i] + vx[i] < 0 || px[i] + vx[i] > XM) vx[i] = -vx[i];
            else px[i] += vx[i];
            if (py[i] + vy[i] < 0 || py[i] + vy[i] > YM) vy[i] = -vy[i];
            else py[i] += vy[i];
        end
    endfunction

    // drive one pixel and queue the result the model predicts for it
    task automatic pix(input int xi, input int yi);
        exp_t        e;
        logic [23:0] t;
        e.color = BG;
        e.mask  = '0;
        e.px    = xi;
        e.py    = yi;
        for (int i = N - 1; i >= 0; i--) begin
            if (xi >= px[i] && xi < px[i] + SIZE && yi >= py[i] && yi < py[i] + SIZE) begin
                t = texel(i, yi - py[i], xi - px[i]);
                if (t != KEY) begin
                    e.mask[i] = 1'b1;
                    e.color   = t;
                end
            end
        end
        @(negedge clk_25mhz);
        x = 10'(xi);
        y = 10'(yi);
        e.stamp = cyc;
        sb.push_back(e);
    endtask

    task automatic tick(input logic [6:0] b);
        @(negedge clk_25mhz);
        btn = b;
        repeat (3) @(negedge clk_25mhz);
        frame_tick = 1'b1;
        @(negedge clk_25mhz);
        frame_tick = 1'b0;
        model_update(b);
    endtask

    always @(posedge clk_25mhz) cyc <= cyc + 1;

    // scoreboard: compare each queued pixel two cycles after it was driven
    always @(negedge clk_25mhz) begin
        exp_t e;
        while (sb.size() > 0 && sb[0].stamp + 2 <= cyc) begin
            e = sb.pop_front();
            check($sformatf("color@%0d,%0d", e.px, e.py), 32'(color), 32'(e.color));
            check($sformatf("mask@%0d,%0d", e.px, e.py), 32'(hit_mask), 32'(e.mask));
        end
    end

    initial begin
        #100_000_000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int          xo, yo;
        logic [6:0]  b;
        bit          found;

        repeat (3) @(negedge clk_25mhz);
        check("rst_color", 32'(color), 32'(BG));
        check("rst_mask", 32'(hit_mask), 32'd0);
        check("rst_collision", 32'(collision), 32'd0);
        model_reset();
        @(negedge clk_25mhz);
        resetn = 1'b1;

        // reset positions, box edges and key texel
        pix(0, 0);     pix(63, 0);    pix(64, 0);    pix(5, 5);
        pix(6, 5);     pix(63, 63);   pix(0, 64);    pix(128, 64);
        pix(127, 64);  pix(191, 127); pix(192, 127); pix(128, 63);
        pix(1023, 1023);

        // opposite buttons cancel
        tick(7'b1100000);
        pix(0, 0); pix(63, 10); pix(64, 10);
        tick(7'b0011000);
        pix(10, 0); pix(10, 63); pix(10, 64);

        // hold right long enough to hit the clamp; watch sprite 1 bounce on the way
        for (int t = 0; t < 600; t++) begin
            tick(7'b1000000);
            pix(px[0] - 1, py[0] + 1);
            pix(px[0], py[0] + 1);
            pix(px[1] - 1, py[1] + 1);
            pix(px[1], py[1] + 1);
        end
        pix(575, 1); pix(576, 1); pix(639, 1); pix(640, 1);

        // steer sprite 0 onto sprite 1
        found = 1'b0;
        for (int t = 0; t < 2000 && !found; t++) begin
            if ((px[0] - px[1]) <= 8 && (px[1] - px[0]) <= 8 &&
                (py[0] - py[1]) <= 8 && (py[1] - py[0]) <= 8) begin
                found = 1'b1;
            end else begin
                b = '0;
                if (px[0] < px[1]) b[6] = 1'b1; else if (px[0] > px[1]) b[5] = 1'b1;
                if (py[0] < py[1]) b[4] = 1'b1; else if (py[0] > py[1]) b[3] = 1'b1;
                tick(b);
            end
        end
        tick(7'b0000000);
        xo = px[0] + 16;
        yo = py[0] + 16;
        if (texel(1, yo - py[1], xo - px[1]) == KEY) xo++;
        pix(1023, 1023);
        repeat (3) @(negedge clk_25mhz);
        pix(xo, yo);
        repeat (4) @(negedge clk_25mhz);
`ifdef SPRITE_COLLISION_EN
        check("collision_set", 32'(collision), 32'd1);
`else
        check("collision_off", 32'(collision), 32'd0);
`endif
        pix(1023, 1023);
        repeat (3) @(negedge clk_25mhz);
        tick(7'b0000000);
        check("collision_clr", 32'(collision), 32'd0);

        // reset mid-frame with an opaque pixel on the outputs
        pix(px[0] + 16, py[0] + 16);
        repeat (4) @(negedge clk_25mhz);
        #10;
        resetn = 1'b0;
        #1;
        check("midrst_color", 32'(color), 32'(BG));
        check("midrst_mask", 32'(hit_mask), 32'd0);
        model_reset();
        @(negedge clk_25mhz);
        resetn = 1'b1;
        pix(0, 0); pix(130, 66); pix(127, 66); pix(200, 200);

        repeat (4) @(negedge clk_25mhz);
        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
